// File: rtl/writeback_buffer.sv
// writeback_buffer: queues evicted cache blocks and drains them to memory with a fixed-length write pulse,
// forwarding still-pending block data to the read path.
module writeback_buffer #(
   parameter int WORD_SIZE   = 8,
   parameter int BLOCK_SIZE  = 1024,
   parameter int DEPTH       = 2,
   parameter int MEM_LATENCY = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wb_valid,
   output logic                       wb_ready,
   input  logic [WORD_SIZE-1:0]       wb_addr,
   input  logic [BLOCK_SIZE-1:0]      wb_data,
   output logic                       mem_writable,
   output logic [WORD_SIZE-1:0]       mem_addr,
   output logic [BLOCK_SIZE-1:0]      mem_write,
   input  logic [WORD_SIZE-1:0]       lookup_addr,
   output logic                       lookup_hit,
   output logic [BLOCK_SIZE-1:0]      lookup_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       busy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int LW = $clog2(MEM_LATENCY + 1);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t                state, next_state;
   logic [WORD_SIZE-1:0]  addr_q [DEPTH];
   logic [BLOCK_SIZE-1:0] data_q [DEPTH];
   logic [PW-1:0]         head, tail, idx;
   logic [LW-1:0]         lat;
   logic                  push, pop;

   assign wb_ready = count != CW'(DEPTH);
   assign push     = wb_valid && wb_ready;
   assign pop      = state == WRITE && lat == LW'(MEM_LATENCY - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         lat   <= '0;
      end else begin
         state <= next_state;
         lat   <= state == WRITE ? lat + 1'b1 : '0;
      end
   end

   always_comb begin
      next_state = state == IDLE ? (count != '0 ? WRITE : IDLE) : (pop ? IDLE : WRITE);
   end

   always_comb begin
      mem_writable = state == WRITE;
      mem_addr     = count != '0 ? addr_q[head] : '0;
      mem_write    = count != '0 ? data_q[head] : '0;
      busy         = count != '0 || state == WRITE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop) head <= head + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Payload needs no reset: count alone decides which slots are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail] <= wb_addr;
         data_q[tail] <= wb_data;
      end
   end

   // Walk oldest to youngest so the youngest match is the one that sticks.
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      idx         = head;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if (CW'(i) < count && addr_q[idx] == lookup_addr) begin
            lookup_hit  = 1'b1;
            lookup_data = data_q[idx];
         end
      end
   end
endmodule

// File: tb/tb_writeback_buffer.sv
module tb_writeback_buffer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          wb_valid, wb_ready, mem_writable, lookup_hit, busy;
   logic [7:0]    wb_addr, mem_addr, lookup_addr;
   logic [1023:0] wb_data, mem_write, lookup_data;
   logic [1:0]    count;

   logic          wb_valid1, wb_ready1, mem_writable1, lookup_hit1, busy1;
   logic [7:0]    wb_addr1, mem_addr1, lookup_addr1;
   logic [1023:0] wb_data1, mem_write1, lookup_data1;
   logic [2:0]    count1;

   writeback_buffer dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
      .mem_writable(mem_writable), .mem_addr(mem_addr), .mem_write(mem_write), .lookup_addr(lookup_addr),
      .lookup_hit(lookup_hit), .lookup_data(lookup_data), .count(count), .busy(busy));

   writeback_buffer #(.DEPTH(4), .MEM_LATENCY(1)) dut1 (
      .clk(clk), .rst(rst), .wb_valid(wb_valid1), .wb_ready(wb_ready1), .wb_addr(wb_addr1), .wb_data(wb_data1),
      .mem_writable(mem_writable1), .mem_addr(mem_addr1), .mem_write(mem_write1), .lookup_addr(lookup_addr1),
      .lookup_hit(lookup_hit1), .lookup_data(lookup_data1), .count(count1), .busy(busy1));

   typedef struct packed {logic [7:0] a; logic [1023:0] d;} ent_t;
   ent_t       sb[$];
   logic [7:0] sb1[$];
   int checks = 0;
   int errors = 0;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push0(input logic [7:0] a, input logic [1023:0] d);
      ent_t e;
      e.a = a;
      e.d = d;
      sb.push_back(e);
      wb_valid = 1'b1;
      wb_addr  = a;
      wb_data  = d;
      step();
      wb_valid = 1'b0;
   endtask

   // Waits (bounded) for a write pulse and reports what it looked like.
   task automatic measure(output bit ok, output int pre, output int len, output bit stable,
                          output logic [7:0] a, output logic [1023:0] d);
      ok = 0; pre = 0; len = 0; stable = 1; a = '0; d = '0;
      while (!mem_writable && pre < 20) begin step(); pre++; end
      if (!mem_writable) return;
      ok = 1; a = mem_addr; d = mem_write;
      while (mem_writable && len < 50) begin
         if (mem_addr !== a || mem_write !== d) stable = 0;
         len++;
         step();
      end
   endtask

   task automatic test_reset();
      repeat (3) step();
      checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL reset_wb_ready got %0b exp 1", wb_ready); end
      checks++; if (mem_writable !== 1'b0) begin errors++; $display("FAIL reset_mem_writable got %0b exp 0", mem_writable); end
      checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got %0h exp 0", mem_addr); end
      checks++; if (mem_write !== '0) begin errors++; $display("FAIL reset_mem_write got %0h exp 0", mem_write[31:0]); end
      checks++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin errors++; $display("FAIL reset_lookup got %0b/%0h exp 0/0", lookup_hit, lookup_data[31:0]); end
      checks++; if (count !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_count_busy got %0d/%0b exp 0/0", count, busy); end
      rst = 1'b0;
      step();
      checks++; if (mem_writable !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL post_reset_idle got %0b/%0d exp 0/0", mem_writable, count); end
   endtask

   task automatic test_single();
      bit ok, st; int pre, len; logic [7:0] a; logic [1023:0] d; ent_t e;
      push0(8'h02, 1024'b11110);
      checks++; if (count !== 2'd1 || mem_writable !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_after_push got cnt=%0d w=%0b b=%0b exp 1/0/1", count, mem_writable, busy); end
      measure(ok, pre, len, st, a, d);
      e = sb.pop_front();
      checks++; if (ok !== 1'b1 || pre !== 1) begin errors++; $display("FAIL single_start got ok=%0b pre=%0d exp 1/1", ok, pre); end
      checks++; if (len !== 4 || st !== 1'b1) begin errors++; $display("FAIL single_pulse got len=%0d stable=%0b exp 4/1", len, st); end
      checks++; if (a !== e.a || d !== e.d) begin errors++; $display("FAIL single_data got %0h/%0h exp %0h/%0h", a, d[31:0], e.a, e.d[31:0]); end
      checks++; if (count !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL single_drained got %0d/%0b exp 0/0", count, busy); end
      step();
   endtask

   task automatic test_back_to_back();
      bit ok, st; int pre, len; logic [7:0] a; logic [1023:0] d; ent_t e;
      push0(8'h10, 1024'hA10);
      push0(8'h11, 1024'hA11);
      checks++; if (wb_ready !== 1'b0 || count !== 2'd2) begin errors++; $display("FAIL b2b_full got rdy=%0b cnt=%0d exp 0/2", wb_ready, count); end
      measure(ok, pre, len, st, a, d);
      e = sb.pop_front();
      checks++; if (ok !== 1'b1 || pre !== 0 || len !== 4 || a !== e.a || d !== e.d) begin errors++; $display("FAIL b2b_first got ok=%0b pre=%0d len=%0d a=%0h exp 1/0/4/%0h", ok, pre, len, a, e.a); end
      checks++; if (wb_ready !== 1'b1 || count !== 2'd1) begin errors++; $display("FAIL b2b_ready_after_pop got %0b/%0d exp 1/1", wb_ready, count); end
      measure(ok, pre, len, st, a, d);
      e = sb.pop_front();
      checks++; if (ok !== 1'b1 || pre !== 1 || len !== 4 || a !== e.a || d !== e.d) begin errors++; $display("FAIL b2b_second got ok=%0b gap=%0d len=%0d a=%0h exp 1/1/4/%0h", ok, pre, len, a, e.a); end
      checks++; if (count !== 2'd0) begin errors++; $display("FAIL b2b_drained got %0d exp 0", count); end
      step();
   endtask

   task automatic test_full_hold();
      bit ok, st; int pre, len, maxc; logic [7:0] a; logic [1023:0] d; ent_t e;
      push0(8'h20, 1024'hB20);
      push0(8'h21, 1024'hB21);
      e = sb.pop_front();
      checks++; if (mem_writable !== 1'b1 || mem_addr !== e.a) begin errors++; $display("FAIL full_first_write got %0b/%0h exp 1/%0h", mem_writable, mem_addr, e.a); end
      wb_valid = 1'b1; wb_addr = 8'h22; wb_data = 1024'hB22;
      maxc = 2;
      for (int k = 2; k <= 5; k++) begin
         step();
         if (int'(count) > maxc) maxc = int'(count);
      end
      checks++; if (count !== 2'd1 || wb_ready !== 1'b1) begin errors++; $display("FAIL full_pop_edge_no_push got cnt=%0d rdy=%0b exp 1/1", count, wb_ready); end
      e.a = 8'h22; e.d = 1024'hB22;
      sb.push_back(e);
      step();
      wb_valid = 1'b0;
      checks++; if (count !== 2'd2) begin errors++; $display("FAIL full_push_next_edge got %0d exp 2", count); end
      checks++; if (maxc > 2) begin errors++; $display("FAIL full_count_bound got %0d exp <=2", maxc); end
      measure(ok, pre, len, st, a, d);
      e = sb.pop_front();
      checks++; if (ok !== 1'b1 || pre !== 0 || len !== 4 || a !== e.a) begin errors++; $display("FAIL full_second got ok=%0b pre=%0d len=%0d a=%0h exp 1/0/4/%0h", ok, pre, len, a, e.a); end
      measure(ok, pre, len, st, a, d);
      e = sb.pop_front();
      checks++; if (ok !== 1'b1 || pre !== 1 || len !== 4 || a !== e.a || d !== e.d) begin errors++; $display("FAIL full_third got ok=%0b pre=%0d len=%0d a=%0h exp 1/1/4/%0h", ok, pre, len, a, e.a); end
      step();
   endtask

   task automatic test_lookup();
      bit ok, st; int pre, len; logic [7:0] a; logic [1023:0] d; ent_t e;
      lookup_addr = 8'h05;
      push0(8'h05, 1024'hAAAA);
      checks++; if (lookup_hit !== 1'b1 || lookup_data !== 1024'hAAAA) begin errors++; $display("FAIL lookup_one got %0b/%0h exp 1/aaaa", lookup_hit, lookup_data[31:0]); end
      push0(8'h05, 1024'hBBBB);
      checks++; if (lookup_hit !== 1'b1 || lookup_data !== 1024'hBBBB) begin errors++; $display("FAIL lookup_youngest got %0b/%0h exp 1/bbbb", lookup_hit, lookup_data[31:0]); end
      lookup_addr = 8'h06; #1;
      checks++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin errors++; $display("FAIL lookup_miss_both got %0b/%0h exp 0/0", lookup_hit, lookup_data[31:0]); end
      lookup_addr = 8'h05; #1;
      measure(ok, pre, len, st, a, d);
      e = sb.pop_front();
      checks++; if (ok !== 1'b1 || a !== e.a || d !== e.d) begin errors++; $display("FAIL lookup_drain_a got %0h exp %0h", d[31:0], e.d[31:0]); end
      checks++; if (lookup_hit !== 1'b1 || lookup_data !== 1024'hBBBB) begin errors++; $display("FAIL lookup_after_a got %0b/%0h exp 1/bbbb", lookup_hit, lookup_data[31:0]); end
      lookup_addr = 8'h06; #1;
      checks++; if (lookup_hit !== 1'b0) begin errors++; $display("FAIL lookup_miss_one got %0b exp 0", lookup_hit); end
      lookup_addr = 8'h05; #1;
      measure(ok, pre, len, st, a, d);
      e = sb.pop_front();
      checks++; if (ok !== 1'b1 || d !== e.d) begin errors++; $display("FAIL lookup_drain_b got %0h exp %0h", d[31:0], e.d[31:0]); end
      checks++; if (lookup_hit !== 1'b0 || lookup_data !== '0) begin errors++; $display("FAIL lookup_after_b got %0b/%0h exp 0/0", lookup_hit, lookup_data[31:0]); end
      step();
   endtask

   task automatic test_reset_mid_write();
      bit seen;
      push0(8'h30, 1024'hC30);
      push0(8'h31, 1024'hC31);
      step();
      checks++; if (mem_writable !== 1'b1) begin errors++; $display("FAIL rstw_in_write got %0b exp 1", mem_writable); end
      #2 rst = 1'b1;
      #1;
      checks++; if (mem_writable !== 1'b0 || count !== 2'd0) begin errors++; $display("FAIL rstw_async got w=%0b cnt=%0d exp 0/0", mem_writable, count); end
      sb.delete();
      step();
      #2 rst = 1'b0;
      seen = 0;
      repeat (20) begin step(); if (mem_writable) seen = 1; end
      checks++; if (seen !== 1'b0 || count !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstw_no_more got seen=%0b cnt=%0d b=%0b exp 0/0/0", seen, count, busy); end
   endtask

   task automatic test_lat1();
      logic [7:0] ea;
      for (int k = 0; k < 7; k++) begin
         if (k < 3) begin
            wb_valid1 = 1'b1;
            wb_addr1  = 8'(8'h40 + k);
            wb_data1  = 1024'(k + 1);
            sb1.push_back(wb_addr1);
         end else wb_valid1 = 1'b0;
         step();
         if (k >= 1) begin
            checks++; if (mem_writable1 !== (k % 2 == 1)) begin errors++; $display("FAIL lat1_pattern_%0d got %0b exp %0b", k, mem_writable1, k % 2 == 1); end
            if (mem_writable1) begin
               ea = sb1.pop_front();
               checks++; if (mem_addr1 !== ea) begin errors++; $display("FAIL lat1_addr_%0d got %0h exp %0h", k, mem_addr1, ea); end
            end
         end
      end
      checks++; if (count1 !== 3'd0 || sb1.size() != 0) begin errors++; $display("FAIL lat1_done got cnt=%0d left=%0d exp 0/0", count1, sb1.size()); end
   endtask

   initial begin
      wb_valid = 0; wb_addr = '0; wb_data = '0; lookup_addr = 8'hFF;
      wb_valid1 = 0; wb_addr1 = '0; wb_data1 = '0; lookup_addr1 = 8'hFF;
      test_reset();
      test_single();
      test_back_to_back();
      test_full_hold();
      test_lookup();
      test_reset_mid_write();
      test_lat1();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
